// File: rtl/mux16_4_rr_collector_pkg.sv
// Shared definitions for the 16-bit four-lane collector / fan-out pair.
// rr_pick is the single source of the round-robin search order.
package mux16_pkg;

    localparam int unsigned WIDTH_DEFAULT = 16;
    localparam int unsigned NUM_CH        = 4;

    typedef logic [1:0] ch_idx_t;

    typedef struct packed {
        logic    found;
        ch_idx_t idx;
    } pick_t;

    // Search starts at last+1 and wraps, so last itself is checked at the end.
    function automatic pick_t rr_pick(input logic [3:0] req, input ch_idx_t last);
        pick_t   p;
        ch_idx_t c;
        p.found = 1'b0;
        p.idx   = last;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            c = last + ch_idx_t'(k);
            if (!p.found && req[c]) begin
                p.found = 1'b1;
                p.idx   = c;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mux16_4_rr_collector_rr_arbiter4.sv
// Four-requester round-robin arbiter holding the last-granted index.
// Grant is one-hot, gated by enable, and only ever set for an asserted request.
module rr_arbiter4
    import mux16_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       enable,
    output logic [3:0] grant,
    output ch_idx_t    idx,
    output logic       found
);

    ch_idx_t last;
    pick_t   pick;

    always_comb begin
        pick  = rr_pick(req, last);
        found = pick.found;
        idx   = pick.idx;
        grant = '0;
        if (enable && pick.found) begin
            grant[pick.idx] = 1'b1;
        end
    end

    // Reset to 3 gives channel 0 first priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 2'd3;
        end else if (enable && pick.found) begin
            last <= pick.idx;
        end
    end

endmodule

// File: rtl/mux16_4_rr_collector.sv
// Four-to-one valid/ready stream collector with a single registered output
// stage; each beat carries its 2-bit source lane index on out_sel.
module mux16_4_rr_collector
    import mux16_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic [WIDTH-1:0] I3,
    input  logic [3:0]       in_valid,
    output logic [3:0]       in_ready,
    output logic [WIDTH-1:0] O,
    output logic [1:0]       out_sel,
    output logic             out_valid,
    input  logic             out_ready
);

    logic             load;
    logic             enable;
    logic             found;
    ch_idx_t          idx;
    logic [3:0]       grant;
    logic [WIDTH-1:0] data;

    assign load   = !out_valid || out_ready;
    // Gating with rst keeps in_ready low during the reset cycle.
    assign enable = load && !rst;

    rr_arbiter4 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (in_valid),
        .enable (enable),
        .grant  (grant),
        .idx    (idx),
        .found  (found)
    );

    assign in_ready = grant;

    always_comb begin
        data = I0;
        case (idx)
            2'd0: data = I0;
            2'd1: data = I1;
            2'd2: data = I2;
            2'd3: data = I3;
            default: data = I0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            O         <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            if (found) begin
                O         <= data;
                out_sel   <= idx;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux16_4_rr_collector.sv
// Directed scoreboard bench: the driver pushes the expected beat on every
// expected grant; a monitor pops and compares each beat accepted downstream.
module tb_mux16_4_rr_collector;
    import mux16_pkg::*;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] I0, I1, I2, I3;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [W-1:0] O;
    logic [1:0]   out_sel;
    logic         out_valid;
    logic         out_ready;

    int checks   = 0;
    int failures = 0;

    logic [17:0] sb[$];

    always #5 clk = ~clk;

    mux16_4_rr_collector #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .I0        (I0),
        .I1        (I1),
        .I2        (I2),
        .I3        (I3),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .O         (O),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Monitor: a beat transfers at the next rising edge when valid and ready.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL beat: unexpected beat O=%h sel=%0d", O, out_sel);
            end else begin
                logic [17:0] e;
                e = sb.pop_front();
                if ({out_sel, O} !== e) begin
                    failures++;
                    $display("FAIL beat: got sel=%0d O=%h, want sel=%0d O=%h",
                             out_sel, O, e[17:16], e[15:0]);
                end
            end
        end
    end

    function automatic logic [1:0] enc(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    // One cycle: drive, check in_ready at negedge, push expected beat on a grant.
    task automatic step(input logic r, input logic [3:0] v, input logic ordy,
                        input logic [3:0] exp_rdy, input logic [W-1:0] exp_data,
                        input string name);
        rst       = r;
        in_valid  = v;
        out_ready = ordy;
        @(negedge clk);
        checks++;
        if (in_ready !== exp_rdy) begin
            failures++;
            $display("FAIL %s in_ready: got %b, want %b", name, in_ready, exp_rdy);
        end
        if (exp_rdy != 4'b0000) sb.push_back({enc(exp_rdy), exp_data});
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input logic ev, input logic [W-1:0] eo,
                           input logic [1:0] es, input string name);
        checks++;
        if (out_valid !== ev || O !== eo || out_sel !== es) begin
            failures++;
            $display("FAIL %s out: got v=%b O=%h sel=%0d, want v=%b O=%h sel=%0d",
                     name, out_valid, O, out_sel, ev, eo, es);
        end
    endtask

    initial begin
        I0 = 16'h1111; I1 = 16'h2222; I2 = 16'h3333; I3 = 16'h4444;

        // Reset with all channels requesting
        step(1'b1, 4'b1111, 1'b1, 4'b0000, '0, "reset0");
        chk_out(1'b0, 16'h0000, 2'd0, "reset0");
        step(1'b1, 4'b1111, 1'b1, 4'b0000, '0, "reset1");
        chk_out(1'b0, 16'h0000, 2'd0, "reset1");

        // Rotation 0,1,2,3,0
        step(1'b0, 4'b1111, 1'b1, 4'b0001, 16'h1111, "rot0");
        step(1'b0, 4'b1111, 1'b1, 4'b0010, 16'h2222, "rot1");
        step(1'b0, 4'b1111, 1'b1, 4'b0100, 16'h3333, "rot2");
        step(1'b0, 4'b1111, 1'b1, 4'b1000, 16'h4444, "rot3");
        step(1'b0, 4'b1111, 1'b1, 4'b0001, 16'h1111, "rot4");

        // Sparse fairness from last=0
        step(1'b0, 4'b0101, 1'b1, 4'b0100, 16'h3333, "sparse0");
        step(1'b0, 4'b0101, 1'b1, 4'b0001, 16'h1111, "sparse1");
        step(1'b0, 4'b0101, 1'b1, 4'b0100, 16'h3333, "sparse2");
        step(1'b0, 4'b0101, 1'b1, 4'b0001, 16'h1111, "sparse3");

        // Back-pressure on a held 0xBEEF from ch1
        I1 = 16'hBEEF;
        step(1'b0, 4'b0010, 1'b1, 4'b0010, 16'hBEEF, "bp_load");
        chk_out(1'b1, 16'hBEEF, 2'd1, "bp_load");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'b1111, 1'b0, 4'b0000, '0, "bp_stall");
            chk_out(1'b1, 16'hBEEF, 2'd1, "bp_stall");
        end
        step(1'b0, 4'b1111, 1'b1, 4'b0100, 16'h3333, "bp_release");
        chk_out(1'b1, 16'h3333, 2'd2, "bp_release");

        // Idle drain of a single ch3 word
        I3 = 16'h00A5;
        step(1'b0, 4'b1000, 1'b1, 4'b1000, 16'h00A5, "idle_load");
        chk_out(1'b1, 16'h00A5, 2'd3, "idle_load");
        step(1'b0, 4'b0000, 1'b1, 4'b0000, '0, "idle_drain");
        chk_out(1'b0, 16'h00A5, 2'd3, "idle_drain");
        step(1'b0, 4'b0000, 1'b1, 4'b0000, '0, "idle_hold");
        chk_out(1'b0, 16'h00A5, 2'd3, "idle_hold");

        // Mid-operation reset discards the held beat; rotation restarts at ch0
        step(1'b0, 4'b0001, 1'b1, 4'b0001, 16'h1111, "mid_load");
        chk_out(1'b1, 16'h1111, 2'd0, "mid_load");
        step(1'b0, 4'b0000, 1'b0, 4'b0000, '0, "mid_stall");
        chk_out(1'b1, 16'h1111, 2'd0, "mid_stall");
        sb.delete();
        step(1'b1, 4'b1111, 1'b1, 4'b0000, '0, "mid_reset");
        chk_out(1'b0, 16'h0000, 2'd0, "mid_reset");
        step(1'b0, 4'b1111, 1'b1, 4'b0001, 16'h1111, "restart0");
        step(1'b0, 4'b1111, 1'b1, 4'b0010, 16'hBEEF, "restart1");
        step(1'b0, 4'b0000, 1'b1, 4'b0000, '0, "tail");

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d beats outstanding, want 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux16_4_rr_collector.md
# mux16_4_rr_collector

Four-to-one 16-bit stream collector: merges four independent valid/ready input channels (I0..I3) into one registered output stream. Each beat is tagged with its 2-bit source index, the same SEL encoding the downstream DMux16_4 fan-out uses, so a round trip through collector and demux routes every word back to its originating lane. Arbitration is round-robin and starvation-free. It sits on the return path of the 16-bit ALU datapath, ahead of the shared result bus.

## Interface
Parameters:
- WIDTH, 16, data width of every channel and of O.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- I0, I1, I2, I3  input  WIDTH each  channel data.
- in_valid  input  4  bit i: channel i presents a word.
- in_ready  output  4  bit i: channel i word accepted this cycle (combinational).
- O  output  WIDTH  registered output word.
- out_sel  output  2  source channel index of O (0..3).
- out_valid  output  1  O/out_sel hold a valid beat.
- out_ready  input  1  downstream accepts the beat this cycle.

## Operation
- Transfer on any interface = valid & ready high in the same cycle.
- Output stage is a single register (O, out_sel, out_valid).
- load = !out_valid | out_ready. The stage can take a new word when empty or when the held word is leaving this cycle.
- When load=1 and in_valid != 0, exactly one channel is granted:
  - in_ready[g] = 1.
  - O <= Ig, out_sel <= g, out_valid <= 1.
  - last <= g.
- When load=1 and in_valid == 0: out_valid <= 0; O and out_sel hold their values.
- When load=0: in_ready = 0000; O, out_sel and out_valid hold.
- Round-robin rule: search order starts at channel (last+1) mod 4 and wraps, so channels are checked last+1, last+2, last+3, last. The first asserted in_valid in that order wins.
  - A channel that keeps in_valid high is served at least once every 4 transfers.
- last is a 2-bit wrap-around counter. It updates only on a grant.
- in_ready is at most one-hot. It is never asserted for a channel whose in_valid is low.
- Input data is not captured unless granted. A producer must hold Ii and in_valid[i] until in_ready[i].
- No combinational path from out_ready to O.
- Combinational paths from in_valid and out_ready to in_ready are permitted and documented.

## Timing
- Reset (rst=1 at a rising edge):
  - O=0, out_sel=0, out_valid=0, last=3, so channel 0 has first priority after reset.
  - While rst=1, in_ready=0000 regardless of inputs.
- Reset mid-operation: a held beat is discarded, with no completion toward downstream. Words offered during the reset cycle are not accepted.
- Latency: a granted word appears on O one cycle after its in_ready cycle.
- Throughput: one beat per cycle with out_ready tied high.
- Back-pressure:
  - out_valid=1 and out_ready=0 stalls the stage: O, out_sel and out_valid stay stable and in_ready=0000.
  - The same cycle out_ready rises, a new grant may occur.
- Simultaneous events:
  - Output drain and new grant in one cycle: the new word replaces the old with no bubble.
  - All four channels valid: grants rotate in the order 0,1,2,3,0...

## Structure
- Shared package mux16_pkg:
  - WIDTH_DEFAULT = 16.
  - Typedef ch_idx_t, 2-bit.
  - Pure function rr_pick(req[3:0], last) returning {found, idx}.
  - The future DMux16_4 wrapper and the testbench use the same package.
- Sub-module rr_arbiter4:
  - Holds last, takes req and enable (= load).
  - Produces one-hot grant and the encoded index.
- Top level contains only load logic, the data mux and the output register.

## Test plan
- Reset: drive rst=1 with in_valid=1111 for 2 cycles -> in_ready=0000, out_valid=0, O=0, out_sel=0. After release, the first grant goes to ch0.
- Rotation: in_valid=1111, I0..I3=0x1111/0x2222/0x3333/0x4444, out_ready=1 -> O sequence 0x1111,0x2222,0x3333,0x4444,0x1111 with out_sel 0,1,2,3,0, one beat per cycle.
- Sparse fairness: in_valid=0101 held, last=0 -> grants 2,0,2,0; channels 1 and 3 never get in_ready.
- Back-pressure: after O=0xBEEF (sel 1) is loaded, hold out_ready=0 for 3 cycles with in_valid=1111 -> O, out_sel and out_valid stable, in_ready=0000. The cycle out_ready=1, the next grant is ch2 and O=I2 the following cycle.
- Idle drain: single word 0x00A5 on ch3, then in_valid=0000 -> out_valid high for exactly one cycle with out_sel=3. O stays 0x00A5 after out_valid falls.
- Mid-operation reset: assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0. The rotation restarts at ch0 after release.
